// File: rtl/gftt_deriv_if.sv
// Pixel-in / gradient-product-out bundle for the GFTT derivative front end.
// The master drives pixels and configuration; the slave returns the products.
interface gftt_deriv_if;
  logic [10:0] wdt_m1;
  logic        start;
  logic        enb;
  logic [7:0]  din;
  logic        vin;
  logic [15:0] dxx;
  logic [15:0] dyy;
  logic [15:0] dxy;
  logic        vout;

  modport master (
    output wdt_m1, start, enb, din, vin,
    input  dxx, dyy, dxy, vout
  );

  modport slave (
    input  wdt_m1, start, enb, din, vin,
    output dxx, dyy, dxy, vout
  );
endinterface

// File: rtl/gftt_deriv.sv
// GFTT front end: 3x3 Sobel on an 8-bit raster stream, emitting Ix*Ix, Iy*Iy, Ix*Iy.
// Five register stages: input, line-buffer read, window, gradients, products.
module gftt_deriv #(
  parameter int SHIFT = 4
) (
  input logic         clk,
  input logic         rst_n,
  gftt_deriv_if.slave bus
);

  localparam int DEPTH = 1024;

  logic [7:0] ram0 [DEPTH];
  logic [7:0] ram1 [DEPTH];

  // stage 1: registered input and raster counters
  logic       vin_q, vin_d;
  logic [7:0] din_q, din_d;
  logic [9:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic       lp_q, lp_d;

  // stage 2: line-buffer read data plus tags
  logic       pv2_q, pv2_d;
  logic       ov2_q, ov2_d;
  logic       bd2_q, bd2_d;
  logic       lp2_q, lp2_d;
  logic [7:0] din2_q, din2_d;
  logic [7:0] rd0_q, rd0_d;
  logic [7:0] rd1_q, rd1_d;

  // stage 3: window, win[r][c] with r0 oldest line and c2 newest column
  logic [2:0][2:0][7:0] win_q, win_d;
  logic                 ov3_q, ov3_d;
  logic                 bd3_q, bd3_d;

  // stage 4: gradients
  logic signed [10:0] ix_q, ix_d;
  logic signed [10:0] iy_q, iy_d;
  logic               ov4_q, ov4_d;
  logic               bd4_q, bd4_d;

  // stage 5: outputs
  logic        vout_q, vout_d;
  logic [15:0] dxx_q, dxx_d;
  logic [15:0] dyy_q, dyy_d;
  logic [15:0] dxy_q, dxy_d;

  logic       line_end;
  logic [7:0] col_old, col_new;
  logic [9:0] sum_r, sum_l, sum_b, sum_t;
  logic signed [21:0] ix_w, iy_w;
  logic signed [21:0] pxx, pyy, pxy;
  logic signed [21:0] sxx, syy, sxy;

  function automatic logic [15:0] sat_u(input logic signed [21:0] v);
    if (v > 22'sd65535)
      return 16'hffff;
    else if (v < 22'sd0)
      return 16'h0000;
    else
      return v[15:0];
  endfunction

  function automatic logic [15:0] sat_s(input logic signed [21:0] v);
    if (v > 22'sd32767)
      return 16'h7fff;
    else if (v < -22'sd32768)
      return 16'h8000;
    else
      return v[15:0];
  endfunction

  assign line_end = vin_q && ({1'b0, col_q} == bus.wdt_m1);

  // The RAM selected by the stage-2 phase still holds the line two back
  // (it is being overwritten by the current line); the other holds the previous line.
  assign col_old = lp2_q ? rd1_q : rd0_q;
  assign col_new = lp2_q ? rd0_q : rd1_q;

  assign sum_r = {2'b00, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b00, win_q[2][2]};
  assign sum_l = {2'b00, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b00, win_q[2][0]};
  assign sum_b = {2'b00, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b00, win_q[2][2]};
  assign sum_t = {2'b00, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b00, win_q[0][2]};

  assign ix_w = 22'(ix_q);
  assign iy_w = 22'(iy_q);
  assign pxx  = ix_w * ix_w;
  assign pyy  = iy_w * iy_w;
  assign pxy  = ix_w * iy_w;
  assign sxx  = pxx >>> SHIFT;
  assign syy  = pyy >>> SHIFT;
  assign sxy  = pxy >>> SHIFT;

  always_comb begin
    vin_d = bus.enb & bus.vin;
    din_d = bus.din;

    col_d = col_q;
    row_d = row_q;
    lp_d  = lp_q;
    if (!bus.enb || bus.start) begin
      col_d = '0;
      row_d = '0;
      lp_d  = 1'b0;
    end else if (vin_q) begin
      if (line_end) begin
        col_d = '0;
        row_d = (row_q == 2'd2) ? 2'd2 : row_q + 2'd1;
        lp_d  = ~lp_q;
      end else begin
        col_d = col_q + 10'd1;
      end
    end

    pv2_d  = vin_q & bus.enb;
    ov2_d  = vin_q & (row_q == 2'd2) & bus.enb;
    bd2_d  = (col_q < 10'd2);
    lp2_d  = lp_q;
    din2_d = din_q;
    rd0_d  = ram0[col_q];
    rd1_d  = ram1[col_q];

    // The window only moves on real pixels so gaps leave it intact.
    win_d = win_q;
    if (pv2_q) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = col_old;
      win_d[1][2] = col_new;
      win_d[2][2] = din2_q;
    end
    ov3_d = ov2_q & bus.enb;
    bd3_d = bd2_q;

    ix_d  = $signed({1'b0, sum_r}) - $signed({1'b0, sum_l});
    iy_d  = $signed({1'b0, sum_b}) - $signed({1'b0, sum_t});
    ov4_d = ov3_q & bus.enb;
    bd4_d = bd3_q;

    vout_d = ov4_q & bus.enb;
    dxx_d  = dxx_q;
    dyy_d  = dyy_q;
    dxy_d  = dxy_q;
    if (bus.enb) begin
      // Columns 0 and 1 straddle the line wrap, so their window is meaningless.
      dxx_d = bd4_q ? 16'h0000 : sat_u(sxx);
      dyy_d = bd4_q ? 16'h0000 : sat_u(syy);
      dxy_d = bd4_q ? 16'h0000 : sat_s(sxy);
    end
  end

  always_ff @(posedge clk) begin
    if (vin_q) begin
      if (lp_q)
        ram1[col_q] <= din_q;
      else
        ram0[col_q] <= din_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vin_q  <= 1'b0;
      din_q  <= '0;
      col_q  <= '0;
      row_q  <= '0;
      lp_q   <= 1'b0;
      pv2_q  <= 1'b0;
      ov2_q  <= 1'b0;
      bd2_q  <= 1'b0;
      lp2_q  <= 1'b0;
      din2_q <= '0;
      rd0_q  <= '0;
      rd1_q  <= '0;
      win_q  <= '0;
      ov3_q  <= 1'b0;
      bd3_q  <= 1'b0;
      ix_q   <= '0;
      iy_q   <= '0;
      ov4_q  <= 1'b0;
      bd4_q  <= 1'b0;
      vout_q <= 1'b0;
      dxx_q  <= '0;
      dyy_q  <= '0;
      dxy_q  <= '0;
    end else begin
      vin_q  <= vin_d;
      din_q  <= din_d;
      col_q  <= col_d;
      row_q  <= row_d;
      lp_q   <= lp_d;
      pv2_q  <= pv2_d;
      ov2_q  <= ov2_d;
      bd2_q  <= bd2_d;
      lp2_q  <= lp2_d;
      din2_q <= din2_d;
      rd0_q  <= rd0_d;
      rd1_q  <= rd1_d;
      win_q  <= win_d;
      ov3_q  <= ov3_d;
      bd3_q  <= bd3_d;
      ix_q   <= ix_d;
      iy_q   <= iy_d;
      ov4_q  <= ov4_d;
      bd4_q  <= bd4_d;
      vout_q <= vout_d;
      dxx_q  <= dxx_d;
      dyy_q  <= dyy_d;
      dxy_q  <= dxy_d;
    end
  end

  assign bus.vout = vout_q;
  assign bus.dxx  = dxx_q;
  assign bus.dyy  = dyy_q;
  assign bus.dxy  = dxy_q;

endmodule

// File: tb/tb_gftt_deriv.sv
// Directed bench for gftt_deriv: 64-wide frames of known patterns, sampled
// outputs compared against hand-computed Sobel products.
module tb_gftt_deriv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gftt_deriv_if bus();
  gftt_deriv dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int pat;
    int ln;
    int col;
    int exp_xx;
    int exp_yy;
    int exp_xy;
  } vec_t;

  vec_t vt[15];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cap_idx = 0;
  int first_vout_cyc = -1;
  int last_drive_cyc = 0;
  int l2_cyc = 0;
  int pre2_cnt = 0;
  logic [15:0] cap_xx [8][64];
  logic [15:0] cap_yy [8][64];
  logic [15:0] cap_xy [8][64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.vout === 1'b1) begin
      if (cap_idx == 0) first_vout_cyc = cyc;
      if (cap_idx < 512) begin
        cap_xx[cap_idx / 64][cap_idx % 64] = bus.dxx;
        cap_yy[cap_idx / 64][cap_idx % 64] = bus.dyy;
        cap_xy[cap_idx / 64][cap_idx % 64] = bus.dxy;
      end
      cap_idx = cap_idx + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d required=%0d", nm, $signed(act), $signed(exp));
    end
  endtask

  function automatic int pix(input int pat, input int r, input int c);
    case (pat)
      0: return 100;
      1: return 4 * c;
      2: return 4 * r;
      3: return (r >= 4 && c >= 8) ? 255 : 0;
      default: return (r >= 4 && c < 8) ? 255 : 0;
    endcase
  endfunction

  task automatic px(input int d, input int gap);
    while (gap > 0 && $urandom_range(0, 99) < gap) begin
      bus.vin = 1'b0;
      @(negedge clk);
    end
    bus.din = 8'(d);
    bus.vin = 1'b1;
    last_drive_cyc = cyc;
    @(negedge clk);
    bus.vin = 1'b0;
  endtask

  task automatic frame_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cap_idx = 0;
    first_vout_cyc = -1;
  endtask

  task automatic stream(input int pat, input int nlines, input int ncols_last, input int gap);
    for (int r = 0; r < nlines; r++) begin
      for (int c = 0; c < 64; c++) begin
        if (r == nlines - 1 && c >= ncols_last) break;
        if (r == 2 && c == 0) pre2_cnt = cap_idx;
        px(pix(pat, r, c), gap);
        if (r == 2 && c == 0) l2_cyc = last_drive_cyc;
      end
    end
  endtask

  task automatic run_frame(input int pat, input int nlines, input int gap);
    frame_start();
    stream(pat, nlines, 64, gap);
    repeat (10) @(negedge clk);
  endtask

  // h-ramp frame: every interior sample is dxx=64, borders 0, dyy=dxy=0
  task automatic bulk_hramp(input string nm);
    int bad;
    int e;
    bad = 0;
    for (int l = 0; l < 6; l++) begin
      for (int c = 0; c < 64; c++) begin
        e = (c < 2) ? 0 : 64;
        if (cap_xx[l][c] !== 16'(e) || cap_yy[l][c] !== 16'h0 || cap_xy[l][c] !== 16'h0)
          bad = bad + 1;
      end
    end
    check(nm, bad, 0);
  endtask

  initial begin
    vt[0]  = '{0, 2, 30, 0, 0, 0};
    vt[1]  = '{0, 5, 63, 0, 0, 0};
    vt[2]  = '{1, 0, 2, 64, 0, 0};
    vt[3]  = '{1, 3, 40, 64, 0, 0};
    vt[4]  = '{1, 5, 63, 64, 0, 0};
    vt[5]  = '{1, 2, 0, 0, 0, 0};
    vt[6]  = '{1, 2, 1, 0, 0, 0};
    vt[7]  = '{2, 1, 10, 0, 64, 0};
    vt[8]  = '{2, 5, 2, 0, 64, 0};
    vt[9]  = '{2, 4, 0, 0, 0, 0};
    vt[10] = '{3, 3, 9, 36576, 36576, 32767};
    vt[11] = '{3, 3, 10, 0, 65025, 0};
    vt[12] = '{3, 2, 9, 4064, 36576, 12192};
    vt[13] = '{3, 1, 9, 0, 0, 0};
    vt[14] = '{4, 3, 8, 36576, 36576, -32768};

    bus.wdt_m1 = 11'd63;
    bus.start  = 1'b0;
    bus.enb    = 1'b0;
    bus.din    = 8'd0;
    bus.vin    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_vout", bus.vout, 0);
    check("reset_dxx", bus.dxx, 0);
    check("reset_dyy", bus.dyy, 0);
    check("reset_dxy", bus.dxy, 0);
    rst_n = 1'b1;
    bus.enb = 1'b1;
    @(negedge clk);

    // T1..T4 plus mirrored quadrant, table-checked
    for (int p = 0; p < 5; p++) begin
      run_frame(p, 8, 0);
      check($sformatf("count_pat%0d", p), cap_idx, 384);
      if (p == 1) bulk_hramp("hramp_all");
      if (p == 2) check("vramp_latency", first_vout_cyc - l2_cyc, 5);
      for (int i = 0; i < 15; i++) begin
        if (vt[i].pat == p) begin
          check($sformatf("p%0d_l%0d_c%0d_dxx", p, vt[i].ln, vt[i].col),
                cap_xx[vt[i].ln][vt[i].col], vt[i].exp_xx);
          check($sformatf("p%0d_l%0d_c%0d_dyy", p, vt[i].ln, vt[i].col),
                cap_yy[vt[i].ln][vt[i].col], vt[i].exp_yy);
          check($sformatf("p%0d_l%0d_c%0d_dxy", p, vt[i].ln, vt[i].col),
                32'($signed(cap_xy[vt[i].ln][vt[i].col])), vt[i].exp_xy);
        end
      end
    end

    // T6: h-ramp with ~50% input gaps
    run_frame(1, 8, 50);
    check("gaps_count", cap_idx, 384);
    bulk_hramp("gaps_all");

    // T5: abandon the frame at line 3 col 20, then restart
    frame_start();
    stream(1, 4, 20, 0);
    repeat (10) @(negedge clk);
    check("partial_count", cap_idx, 84);
    run_frame(1, 4, 0);
    check("restart_pre_line2", pre2_cnt, 0);
    check("restart_count", cap_idx, 128);
    check("restart_latency", first_vout_cyc - l2_cyc, 5);
    check("restart_c0", cap_xx[0][0], 0);
    check("restart_c2", cap_xx[0][2], 64);
    check("restart_c63", cap_xx[1][63], 64);

    // enb drop mid-line: vout off next cycle, data held
    frame_start();
    stream(1, 4, 10, 0);
    check("enb_pre_vout", bus.vout, 1);
    bus.enb = 1'b0;
    @(negedge clk);
    check("enb_vout", bus.vout, 0);
    check("enb_hold_dxx", bus.dxx, 64);
    repeat (3) @(negedge clk);
    check("enb_vout_later", bus.vout, 0);
    check("enb_hold_later", bus.dxx, 64);
    bus.enb = 1'b1;
    @(negedge clk);

    // reset asserted mid-line while vout is active
    frame_start();
    stream(1, 4, 5, 0);
    check("rst_pre_vout", bus.vout, 1);
    bus.din = 8'd20;
    bus.vin = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_vout", bus.vout, 0);
    check("rst_dxx", bus.dxx, 0);
    @(negedge clk);
    bus.vin = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(1, 4, 0);
    check("post_rst_count", cap_idx, 128);
    check("post_rst_c5", cap_xx[1][5], 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
